// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode encoding, flag bit positions
// inside the {Z,C,S,P} flag word, and the control FSM states.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_MOV  = 4'h0, OP_ADD  = 4'h1, OP_ADC = 4'h2, OP_SUB  = 4'h3,
    OP_SBC  = 4'h4, OP_CMP  = 4'h5, OP_AND = 4'h6, OP_OR   = 4'h7,
    OP_XOR  = 4'h8, OP_NOT  = 4'h9, OP_SHL = 4'hA, OP_SHR  = 4'hB,
    OP_ASR  = 4'hC, OP_MUL  = 4'hD, OP_MULH = 4'hE, OP_RSV = 4'hF
  } op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_P = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_flags.sv
// Combinational zero/sign/even-parity flag generation for a WIDTH-bit value.
module alu_seq_flags
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] res,
  output logic             z,
  output logic             s,
  output logic             p
);

  assign z = (res == '0);
  assign s = res[WIDTH-1];
  assign p = ~^res;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with registered {Z,C,S,P} flags and START/BUSY/DONE handshake.
// Define ALU_SEQ_MUL_EN to build the shift-add MUL/MULH engine; otherwise D/E are illegal.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             FLAGS_LD,
  input  logic [3:0]       FLAGS_DIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             WE,
  output logic             ILLEGAL,
  output logic [3:0]       FLAGS
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             we_q, we_d;
  logic             ill_q, ill_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH-1:0] fres;
  logic             fcarry;
  logic             fupd;
  logic             z_w, s_w, p_w;
  logic [WIDTH-1:0] shv;
  logic             shc;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_nxt;
  logic [WIDTH:0]     psum;

  // Shift-add step: accumulate A into the high half when the multiplier LSB is set.
  assign psum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);
  assign prod_nxt = {psum, prod_q[WIDTH-1:1]};
`endif

  alu_seq_flags #(.WIDTH(WIDTH)) u_flags (
    .res (fres),
    .z   (z_w),
    .s   (s_w),
    .p   (p_w)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    ill_d    = 1'b0;
    fres     = '0;
    fcarry   = flags_q[FLAG_C];
    fupd     = 1'b0;
    shv      = '0;
    shc      = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    prod_d   = prod_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) begin
          done_d = 1'b1;
          we_d   = 1'b1;
          fupd   = 1'b1;
          case (op_e'(OP))
            OP_MOV: begin fres = A; fcarry = 1'b0; end
            OP_ADD: {fcarry, fres} = {1'b0, A} + {1'b0, B};
            OP_ADC: {fcarry, fres} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CIN};
            OP_SUB, OP_CMP: {fcarry, fres} = {1'b0, A} - {1'b0, B};
            OP_SBC: {fcarry, fres} = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, CIN};
            OP_AND: begin fres = A & B; fcarry = 1'b0; end
            OP_OR:  begin fres = A | B; fcarry = 1'b0; end
            OP_XOR: begin fres = A ^ B; fcarry = 1'b0; end
            OP_NOT: begin fres = ~A;    fcarry = 1'b0; end
            OP_SHL, OP_SHR, OP_ASR: begin
              // A zero count completes immediately with A and the old carry.
              fres = A;
              if (B[SHW-1:0] != '0) begin
                done_d  = 1'b0;
                we_d    = 1'b0;
                fupd    = 1'b0;
                state_d = SHIFT;
                op_d    = op_e'(OP);
                opa_d   = A;
                cnt_d   = B[SHW-1:0] - SHW'(1);
              end
            end
            OP_MUL, OP_MULH: begin
              we_d = 1'b0;
              fupd = 1'b0;
`ifdef ALU_SEQ_MUL_EN
              done_d  = 1'b0;
              state_d = MUL;
              op_d    = op_e'(OP);
              opa_d   = A;
              prod_d  = {{WIDTH{1'b0}}, B};
              cnt_d   = '1;
`else
              ill_d = 1'b1;
`endif
            end
            default: begin
              we_d  = 1'b0;
              fupd  = 1'b0;
              ill_d = 1'b1;
            end
          endcase
          if (op_e'(OP) == OP_CMP) we_d = 1'b0;
          if (we_d) result_d = fres;
        end
      end
      SHIFT: begin
        case (op_q)
          OP_SHL:  begin shv = {opa_q[WIDTH-2:0], 1'b0};      shc = opa_q[WIDTH-1]; end
          OP_ASR:  begin shv = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]}; shc = opa_q[0]; end
          default: begin shv = {1'b0, opa_q[WIDTH-1:1]};      shc = opa_q[0]; end
        endcase
        opa_d = shv;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          we_d     = 1'b1;
          fupd     = 1'b1;
          fres     = shv;
          fcarry   = shc;
          result_d = shv;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        prod_d = prod_nxt;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          we_d    = 1'b1;
          fupd    = 1'b1;
          if (op_q == OP_MULH) begin
            fres   = prod_nxt[2*WIDTH-1:WIDTH];
            fcarry = |prod_nxt[WIDTH-1:0];
          end else begin
            fres   = prod_nxt[WIDTH-1:0];
            fcarry = |prod_nxt[2*WIDTH-1:WIDTH];
          end
          result_d = fres;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // An external flag restore overrides whatever the completing op computed.
  always_comb begin
    flags_d = flags_q;
    if (fupd) begin
      flags_d[FLAG_Z] = z_w;
      flags_d[FLAG_C] = fcarry;
      flags_d[FLAG_S] = s_w;
      flags_d[FLAG_P] = p_w;
    end
    if (FLAGS_LD) flags_d = FLAGS_DIN;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      ill_q    <= 1'b0;
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      we_q     <= we_d;
      ill_q    <= ill_d;
      flags_q  <= flags_d;
    end
  end

  always_ff @(posedge CLK) begin
    op_q  <= op_d;
    opa_q <= opa_d;
    cnt_q <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
    prod_q <= prod_d;
`endif
  end

  assign BUSY    = (state_q != IDLE);
  assign DONE    = done_q;
  assign RESULT  = result_q;
  assign WE      = we_q;
  assign ILLEGAL = ill_q;
  assign FLAGS   = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16 main instance, WIDTH=8 side instance).
module tb_alu_seq;

  typedef struct {
    logic [15:0] res;
    logic        we;
    logic        ill;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        use_ref;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, cin, fld;
  logic [3:0]  op, fdin;
  logic [15:0] a, b;
  logic        busy, done, we, ill;
  logic [15:0] result;
  logic [3:0]  flags;

  logic        start8, cin8, fld8;
  logic [3:0]  op8, fdin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, we8, ill8;
  logic [7:0]  result8;
  logic [3:0]  flags8;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  logic [15:0] m_res;
  logic [3:0]  m_fl;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) dut (
    .CLK(clk), .RESETN(resetn), .START(start), .OP(op), .A(a), .B(b), .CIN(cin),
    .FLAGS_LD(fld), .FLAGS_DIN(fdin), .BUSY(busy), .DONE(done), .RESULT(result),
    .WE(we), .ILLEGAL(ill), .FLAGS(flags)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .CLK(clk), .RESETN(resetn), .START(start8), .OP(op8), .A(a8), .B(b8), .CIN(cin8),
    .FLAGS_LD(fld8), .FLAGS_DIN(fdin8), .BUSY(busy8), .DONE(done8), .RESULT(result8),
    .WE(we8), .ILLEGAL(ill8), .FLAGS(flags8)
  );

  // Reference model written with integer arithmetic and bit loops.
  function automatic exp_t ref_op(input logic [3:0] o, input logic [15:0] av, bv,
                                  input logic c_in, input logic [15:0] pres,
                                  input logic [3:0] pfl);
    exp_t        e;
    int unsigned sa, sb, t;
    logic [15:0] v;
    logic        c;
    logic [31:0] p;
    int          k;
    sa = av; sb = bv; v = 16'h0; c = 1'b0; p = 32'h0;
    e.we = 1'b1; e.ill = 1'b0; e.lat = 1; e.res = pres; e.fl = pfl;
    case (o)
      4'h0: v = av;
      4'h1: begin t = sa + sb; v = t[15:0]; c = (t > 32'hFFFF); end
      4'h2: begin t = sa + sb + c_in; v = t[15:0]; c = (t > 32'hFFFF); end
      4'h3, 4'h5: begin v = av - bv; c = (sa < sb); end
      4'h4: begin v = av - bv - {15'b0, c_in}; c = (sa < sb + c_in); end
      4'h6: v = av & bv;
      4'h7: v = av | bv;
      4'h8: v = av ^ bv;
      4'h9: v = ~av;
      4'hA, 4'hB, 4'hC: begin
        k = int'(bv[3:0]); v = av; c = pfl[2];
        for (int i = 0; i < k; i++) begin
          if (o == 4'hA) begin c = v[15]; v = v << 1; end
          else if (o == 4'hB) begin c = v[0]; v = v >> 1; end
          else begin c = v[0]; v = $signed(v) >>> 1; end
        end
        e.lat = (k == 0) ? 1 : k + 1;
      end
`ifdef ALU_SEQ_MUL_EN
      4'hD, 4'hE: begin
        p = sa * sb;
        if (o == 4'hD) begin v = p[15:0]; c = |p[31:16]; end
        else begin v = p[31:16]; c = |p[15:0]; end
        e.lat = 17;
      end
`endif
      default: begin e.we = 1'b0; e.ill = 1'b1; end
    endcase
    if (o == 4'h5) e.we = 1'b0;
    if (e.we) e.res = v;
    if (!e.ill) e.fl = {v == 16'h0, c, v[15], ($countones(v) % 2) == 0};
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] o, input logic [15:0] av, bv, input logic c,
                              input logic [15:0] r, input logic w, il, input logic [3:0] f,
                              input int l);
    vec_t v;
    v.op = o; v.a = av; v.b = bv; v.cin = c; v.use_ref = 1'b0;
    v.e.res = r; v.e.we = w; v.e.ill = il; v.e.fl = f; v.e.lat = l;
    return v;
  endfunction

  function automatic vec_t rv(input logic [3:0] o, input logic [15:0] av, bv, input logic c);
    vec_t v;
    v = mk(o, av, bv, c, 16'h0, 1'b0, 1'b0, 4'h0, 0);
    v.use_ref = 1'b1;
    return v;
  endfunction

  // Drives one op, scrambles inputs after capture, waits (bounded) for DONE.
  task automatic do_op(input logic [3:0] o, input logic [15:0] av, bv, input logic c,
                       output int lat, output int bsy, output logic [15:0] r,
                       output logic w, output logic il, output logic [3:0] f, output logic bz);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv; cin = c;
    @(negedge clk);
    start = 1'b0; op = 4'($urandom); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    lat = 1; bsy = 0;
    while (!done && lat < 64) begin
      if (busy) bsy++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    r = result; w = we; il = ill; f = flags; bz = busy;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, we, ill, result, flags} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset16: busy/done/we/ill/result/flags got %b%b%b%b/%h/%b required 0000/0000/0000",
               busy, done, we, ill, result, flags);
    end
    n_cmp++;
    if ({busy8, done8, we8, ill8, result8, flags8} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset8: busy/done/we/ill/result/flags got %b%b%b%b/%h/%b required 0000/00/0000",
               busy8, done8, we8, ill8, result8, flags8);
    end
    resetn = 1'b1;
    m_res = 16'h0; m_fl = 4'h0;
  endtask

  task automatic test_single();
    vec_t v[$];
    exp_t e;
    int lat, bsy;
    logic [15:0] r; logic w, il, bz; logic [3:0] f;
    v.push_back(mk(4'h3, 16'h1110, 16'h1111, 1'b0, 16'hFFFF, 1, 0, 4'b0111, 1));
    v.push_back(mk(4'h5, 16'h1110, 16'h1111, 1'b0, 16'hFFFF, 0, 0, 4'b0111, 1));
    v.push_back(mk(4'h6, 16'h1111, 16'h2222, 1'b0, 16'h0000, 1, 0, 4'b1001, 1));
    v.push_back(mk(4'h1, 16'h4444, 16'h1111, 1'b0, 16'h5555, 1, 0, 4'b0001, 1));
    v.push_back(mk(4'h2, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1, 0, 4'b1101, 1));
    v.push_back(mk(4'hF, 16'h1234, 16'h5678, 1'b0, 16'h0000, 0, 1, 4'b1101, 1));
    v.push_back(mk(4'h4, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1, 0, 4'b0111, 1));
    v.push_back(mk(4'h9, 16'h00FF, 16'h0000, 1'b0, 16'hFF00, 1, 0, 4'b0011, 1));
    for (int i = 0; i < 10; i++)
      v.push_back(rv(4'($urandom_range(0, 9)), 16'($urandom), 16'($urandom), 1'($urandom)));
    foreach (v[i]) begin
      if (v[i].use_ref) e = ref_op(v[i].op, v[i].a, v[i].b, v[i].cin, m_res, m_fl);
      else e = v[i].e;
      exp_q.push_back(e);
      m_res = e.res; m_fl = e.fl;
      do_op(v[i].op, v[i].a, v[i].b, v[i].cin, lat, bsy, r, w, il, f, bz);
      e = exp_q.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin
        n_bad++;
        $display("FAIL single[%0d] op%h latency: got %0d required %0d", i, v[i].op, lat, e.lat);
      end
      n_cmp++;
      if ({r, w, il, f, bz} !== {e.res, e.we, e.ill, e.fl, 1'b0}) begin
        n_bad++;
        $display("FAIL single[%0d] op%h res/we/ill/flags/busy: got %h/%b/%b/%b/%b required %h/%b/%b/%b/0",
                 i, v[i].op, r, w, il, f, bz, e.res, e.we, e.ill, e.fl);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[$];
    exp_t e;
    int lat, bsy;
    logic [15:0] r; logic w, il, bz; logic [3:0] f;
    v.push_back(mk(4'hA, 16'h8001, 16'h0001, 1'b0, 16'h0002, 1, 0, 4'b0100, 2));
    v.push_back(mk(4'hB, 16'h0001, 16'h0000, 1'b0, 16'h0001, 1, 0, 4'b0100, 1));
    v.push_back(mk(4'hC, 16'h8000, 16'h000F, 1'b0, 16'hFFFF, 1, 0, 4'b0011, 16));
    v.push_back(mk(4'hB, 16'hFFFF, 16'hFFF4, 1'b0, 16'h0FFF, 1, 0, 4'b0101, 5));
    for (int i = 0; i < 6; i++)
      v.push_back(rv(4'($urandom_range(10, 12)), 16'($urandom),
                     {12'($urandom), 4'($urandom_range(0, 15))}, 1'b0));
    foreach (v[i]) begin
      if (v[i].use_ref) e = ref_op(v[i].op, v[i].a, v[i].b, v[i].cin, m_res, m_fl);
      else e = v[i].e;
      exp_q.push_back(e);
      m_res = e.res; m_fl = e.fl;
      do_op(v[i].op, v[i].a, v[i].b, v[i].cin, lat, bsy, r, w, il, f, bz);
      e = exp_q.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin
        n_bad++;
        $display("FAIL shift[%0d] op%h latency: got %0d required %0d", i, v[i].op, lat, e.lat);
      end
      n_cmp++;
      if (bsy !== e.lat - 1) begin
        n_bad++;
        $display("FAIL shift[%0d] busy cycles: got %0d required %0d", i, bsy, e.lat - 1);
      end
      n_cmp++;
      if ({r, w, il, f, bz} !== {e.res, e.we, e.ill, e.fl, 1'b0}) begin
        n_bad++;
        $display("FAIL shift[%0d] op%h res/we/ill/flags/busy: got %h/%b/%b/%b/%b required %h/%b/%b/%b/0",
                 i, v[i].op, r, w, il, f, bz, e.res, e.we, e.ill, e.fl);
      end
    end
  endtask

  task automatic test_mul();
    vec_t v[$];
    exp_t e;
    int lat, bsy;
    logic [15:0] r; logic w, il, bz; logic [3:0] f;
`ifdef ALU_SEQ_MUL_EN
    v.push_back(mk(4'hD, 16'h0123, 16'h0100, 1'b0, 16'h2300, 1, 0, 4'b0100, 17));
    v.push_back(mk(4'hE, 16'h0123, 16'h0100, 1'b0, 16'h0001, 1, 0, 4'b0100, 17));
    v.push_back(rv(4'hD, 16'($urandom), 16'($urandom), 1'b0));
    v.push_back(rv(4'hE, 16'($urandom), 16'($urandom), 1'b0));
`else
    v.push_back(mk(4'hD, 16'h0123, 16'h0100, 1'b0, m_res, 0, 1, m_fl, 1));
    v.push_back(mk(4'hE, 16'h0123, 16'h0100, 1'b0, m_res, 0, 1, m_fl, 1));
`endif
    foreach (v[i]) begin
      if (v[i].use_ref) e = ref_op(v[i].op, v[i].a, v[i].b, v[i].cin, m_res, m_fl);
      else e = v[i].e;
      exp_q.push_back(e);
      m_res = e.res; m_fl = e.fl;
      do_op(v[i].op, v[i].a, v[i].b, v[i].cin, lat, bsy, r, w, il, f, bz);
      e = exp_q.pop_front();
      n_cmp++;
      if (lat !== e.lat || bsy !== e.lat - 1) begin
        n_bad++;
        $display("FAIL mul[%0d] latency/busy: got %0d/%0d required %0d/%0d", i, lat, bsy, e.lat, e.lat - 1);
      end
      n_cmp++;
      if ({r, w, il, f, bz} !== {e.res, e.we, e.ill, e.fl, 1'b0}) begin
        n_bad++;
        $display("FAIL mul[%0d] op%h res/we/ill/flags/busy: got %h/%b/%b/%b/%b required %h/%b/%b/%b/0",
                 i, v[i].op, r, w, il, f, bz, e.res, e.we, e.ill, e.fl);
      end
    end
  endtask

  // Long op, ignored second START at cycle 5, reset at cycle 8.
  task automatic test_abort();
    logic       seen;
    logic [3:0] f0;
    f0 = flags;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1; cin = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    op = 4'hD; a = 16'h0123; b = 16'h0100;
`else
    op = 4'hA; a = 16'h0123; b = 16'h000F;
`endif
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      seen |= done;
      if (cyc == 7) begin
        n_cmp++;
        if (busy !== 1'b1 || flags !== f0) begin
          n_bad++;
          $display("FAIL abort busy/flags at cycle 7: got %b/%b required 1/%b", busy, flags, f0);
        end
      end
      if (cyc == 9) begin
        n_cmp++;
        if ({busy, done, flags} !== 6'b0) begin
          n_bad++;
          $display("FAIL abort after reset busy/done/flags: got %b/%b/%b required 0/0/0000", busy, done, flags);
        end
      end
      start = (cyc == 5);
      op = 4'h1; a = 16'h0001; b = 16'h0001;
      resetn = (cyc != 8);
    end
    start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= done;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abort DONE seen: got %b required 0", seen);
    end
    m_res = 16'h0; m_fl = 4'h0;
  endtask

  task automatic test_flags_ld();
    exp_t e;
    @(negedge clk);
    fld = 1'b1; fdin = 4'b0101;
    @(negedge clk);
    fld = 1'b0;
    n_cmp++;
    if (flags !== 4'b0101 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL flags_ld idle flags/done: got %b/%b required 0101/0", flags, done);
    end
    e.res = 16'h5555; e.we = 1'b1; e.ill = 1'b0; e.fl = 4'b1010; e.lat = 1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op = 4'h1; a = 16'h4444; b = 16'h1111; cin = 1'b0; fld = 1'b1; fdin = 4'b1010;
    @(negedge clk);
    start = 1'b0; fld = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if ({done, result, we, flags} !== {1'b1, e.res, e.we, e.fl}) begin
      n_bad++;
      $display("FAIL flags_ld add done/res/we/flags: got %b/%h/%b/%b required 1/%h/%b/%b",
               done, result, we, flags, e.res, e.we, e.fl);
    end
    m_res = e.res; m_fl = e.fl;
  endtask

  task automatic test_width8();
    logic [7:0] er [2];
    logic [3:0] ef [2];
    er[0] = 8'h00; ef[0] = 4'b1101;
    er[1] = 8'h00; ef[1] = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start8 = 1'b1; op8 = 4'h1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
      fld8 = (i == 1); fdin8 = 4'b1010;
      @(negedge clk);
      start8 = 1'b0; fld8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      n_cmp++;
      if ({done8, result8, we8, flags8} !== {1'b1, er[i], 1'b1, ef[i]}) begin
        n_bad++;
        $display("FAIL width8[%0d] done/res/we/flags: got %b/%h/%b/%b required 1/%h/1/%b",
                 i, done8, result8, we8, flags8, er[i], ef[i]);
      end
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; op = 4'h0; a = 16'h0; b = 16'h0; cin = 1'b0;
    fld = 1'b0; fdin = 4'h0;
    start8 = 1'b0; op8 = 4'h0; a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0; fld8 = 1'b0; fdin8 = 4'h0;
    test_reset();
    test_single();
    test_shift();
    test_mul();
    test_abort();
    test_flags_ld();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised multi-cycle ALU with a registered flag file (Z, C, S, P). It replaces the fixed 16-bit single-cycle ALU path in the core's EXECUTE stage. Single-cycle ops complete in one clock. Shifts by N and multiply are sequential engines, and the core sequences them through a START/BUSY/DONE handshake. The flag register is the source for the conditional-skip logic (CC_SELECT) and can be reloaded for interrupt return.

Parameters:
WIDTH, 16, datapath width in bits (≥4, power of 2)
SHW, $clog2(WIDTH), width of the shift-count field taken from B

Ports:
CLK  in  1  system clock
RESETN  in  1  synchronous active-low reset, sampled on rising CLK
START  in  1  launch op; accepted only when BUSY=0
OP  in  4  opcode, sampled with START
A  in  WIDTH  operand A / destination value
B  in  WIDTH  operand B; shifts use B[SHW-1:0]
CIN  in  1  carry-in for ADC/SBC, sampled with START
FLAGS_LD  in  1  load flag register from FLAGS_DIN
FLAGS_DIN  in  4  {Z,C,S,P} restore value
BUSY  out  1  multi-cycle op in progress
DONE  out  1  one-cycle pulse: RESULT/WE/ILLEGAL valid
RESULT  out  WIDTH  registered result, held until next DONE
WE  out  1  with DONE: destination register write required
ILLEGAL  out  1  with DONE: reserved/disabled opcode
FLAGS  out  4  registered {Z,C,S,P}

Behaviour:
- Reset (RESETN=0 at a rising edge): state IDLE; BUSY, DONE, WE, ILLEGAL = 0; RESULT = 0; FLAGS = 4'b0000. Reset aborts any op in progress. No DONE is produced for the aborted op.
- Opcodes: 0 MOV, 1 ADD, 2 ADC, 3 SUB, 4 SBC, 5 CMP, 6 AND, 7 OR, 8 XOR, 9 NOT, A SHL, B SHR, C ASR, D MUL (low half), E MULH (high half), F reserved.
- Single-cycle ops (0-9, F): START at edge n → DONE=1 for the cycle following edge n+1, i.e. 1-cycle latency. BUSY stays 0.
- CMP computes A-B and updates flags with WE=0. It has the same latency as the other single-cycle ops.
- F: WE=0, ILLEGAL=1, flags unchanged.
- Flags on WE/CMP ops: Z = (result==0); S = result[WIDTH-1]; P = even parity of result (1 = even count of ones).
- C per op: ADD/ADC carry-out; SUB/SBC/CMP borrow (A<B unsigned, including CIN for SBC); logic ops and MOV clear C.
- Shift ops: C = last bit shifted out. Count 0 leaves C unchanged.
- MUL/MULH: C = 1 if the high half is nonzero (MUL) or the low half is nonzero (MULH).
- State machine: IDLE → SHIFT (ops A-C with count>0) → IDLE. IDLE → MUL (ops D/E) → IDLE.
- SHIFT: one bit per cycle. Count k gives BUSY for k cycles and DONE on cycle k+1 after START. Count 0 behaves as a single-cycle op: RESULT=A, flags recomputed except C.
- MUL: shift-add, one bit per cycle. BUSY for WIDTH cycles, DONE at cycle WIDTH+1.
- BUSY rises the cycle after START and falls in the same cycle DONE rises.
- START while BUSY=1 is ignored; no queueing.
- A, B, OP and CIN are captured at START; later changes have no effect.
- FLAGS_LD: FLAGS ← FLAGS_DIN next cycle. If it coincides with a flag-updating DONE, FLAGS_LD wins and the op's flags are dropped. RESULT and WE are unaffected.
- FLAGS change only on DONE or FLAGS_LD.

Optional Feature:
ALU_SEQ_MUL_EN
- Defined: MUL/MULH engine built as above.
- Undefined: no multiplier or MUL state. OP D/E complete single-cycle with ILLEGAL=1, WE=0, flags unchanged, RESULT unchanged.

Decomposition:
- Shared package alu_seq_pkg: OP enum (4-bit), flag index constants FLAG_Z/C/S/P, state enum {IDLE, SHIFT, MUL}.
- One sub-module alu_seq_flags: combinational Z/S/P generation from result, parametrised by WIDTH. It is reused by the core's debug flag view.

Test Plan:
- SUB A=0x1110 B=0x1111 (WIDTH=16) → DONE after 1 cycle, RESULT=0xFFFF, WE=1, FLAGS Z0 C1 S1 P1. Repeat as CMP → RESULT unchanged, WE=0, same flags.
- AND A=0x1111 B=0x2222 → RESULT=0x0000, Z1 C0 S0 P1. ADD 0x4444+0x1111 → 0x5555, C0. ADC 0xFFFF+0x0000 CIN=1 → 0x0000, Z1 C1.
- SHL A=0x8001 B=1 → BUSY 1 cycle, DONE cycle 2, RESULT=0x0002, C1. SHR A=0x0001 B=0 → 1-cycle DONE, RESULT=0x0001, C unchanged.
- MUL A=0x0123 B=0x0100 → BUSY 16 cycles, DONE at cycle 17, RESULT=0x2300, C1. MULH → RESULT=0x0001. Without ALU_SEQ_MUL_EN → 1-cycle DONE, ILLEGAL=1.
- START MUL, then START again at cycle 5 → second START ignored. Assert RESETN=0 at cycle 8 → no DONE; BUSY=0 and FLAGS=0 next cycle.
- FLAGS_LD=1 FLAGS_DIN=4'b1010 in the same cycle as an ADD's DONE → FLAGS=1010, RESULT still the ADD result. Repeat at WIDTH=8: 0x80+0x80 → 0x00, Z1 C1.
